uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions (receiver now, transmitter later); PARITY state only with UART_RX_PARITY_EN.
// No logic here: constants and the FSM state type only.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high async line; 2-cycle latency, no backpressure.
// Resets to 1 so the receiver sees an idle line while in reset.
module uart_sync2 (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, LSB first; optional even parity via UART_RX_PARITY_EN.
// Done/error pulses one clock after the stop-bit sample tick; no backpressure, a frame is never stalled.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_frame_err
);

  localparam int              NW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]      S_MID       = 4'(MID_START);
  localparam logic [3:0]      S_BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      S_STOP_LAST = 4'(STOP_TICKS - 1);
  localparam logic [NW-1:0]   N_LAST      = NW'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic                 armed_q, armed_d;
  logic [3:0]           s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 load;
  logic                 rx;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_sync2 u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      // A start edge only counts once the line has been seen idle, so a break yields one frame.
      IDLE: begin
        if (rx) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          s_d     = 4'd0;
          armed_d = 1'b0;
        end
      end
      START: if (i_tick) begin
        if (s_q == S_MID) begin
          s_d     = 4'd0;
          n_d     = '0;
          state_d = rx ? IDLE : DATA;
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      DATA: if (i_tick) begin
        if (s_q == S_BIT_LAST) begin
          s_d     = 4'd0;
          shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
          if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          s_d = s_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (i_tick) begin
        if (s_q == S_BIT_LAST) begin
          s_d     = 4'd0;
          par_d   = rx;
          state_d = STOP;
        end else begin
          s_d = s_q + 4'd1;
        end
      end
`endif
      STOP: if (i_tick) begin
        if (s_q == S_STOP_LAST) begin
          s_d     = 4'd0;
          load    = 1'b1;
          state_d = IDLE;
        end else begin
          s_d = s_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      s_q          <= 4'd0;
      n_q          <= '0;
      shreg_q      <= '0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      s_q          <= s_d;
      n_q          <= n_d;
      shreg_q      <= shreg_d;
      o_rx_done    <= load;
      o_frame_err  <= load & ~rx;
      if (load) o_data <= shreg_q;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      o_parity_err <= load & ((^shreg_q) ^ par_q);
`endif
    end
  end

endmodule
